// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 scan bounds and RGB444 helpers
package vga_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    function automatic logic [3:0] rgb_r(input rgb12_t c);
        return c[11:8];
    endfunction

    function automatic logic [3:0] rgb_g(input rgb12_t c);
        return c[7:4];
    endfunction

    function automatic logic [3:0] rgb_b(input rgb12_t c);
        return c[3:0];
    endfunction

endpackage

// File: rtl/vga_scan_driver_delay_line.sv
// rtl/vga_scan_driver_delay_line.sv - enabled shift register with synchronous reset value
module vga_delay_line #(
    parameter int                 WIDTH     = 4,
    parameter int                 DEPTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA timing master: pixel tick, scan counters, aligned RGB/sync pins
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int     CLK_DIV   = 4,
    parameter int     H_VISIBLE = VGA_H_VISIBLE,
    parameter int     H_FRONT   = VGA_H_FRONT,
    parameter int     H_SYNC    = VGA_H_SYNC,
    parameter int     H_BACK    = VGA_H_BACK,
    parameter int     V_VISIBLE = VGA_V_VISIBLE,
    parameter int     V_FRONT   = VGA_V_FRONT,
    parameter int     V_SYNC    = VGA_V_SYNC,
    parameter int     V_BACK    = VGA_V_BACK,
    parameter int     PIPE_LAT  = 1,
    parameter rgb12_t BG_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        pix_en,
    input  logic [11:0] pixel_in,
    input  logic        pixel_valid,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt;
    logic       hs_raw, vs_raw, on_raw;
    logic       hs_d, vs_d, on_d, valid_d;
    rgb12_t     rgb;

    // pix_en is registered from the divider, so the first strobe after
    // release lands exactly CLK_DIV clocks later, including CLK_DIV=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign on_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    assign frame_start = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Timing flags wait out the generators' read latency so they meet pixel_in.
    vga_delay_line #(
        .WIDTH     (4),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (4'b1100)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  ({hs_raw, vs_raw, on_raw, pixel_valid}),
        .dout ({hs_d, vs_d, on_d, valid_d})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb      <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else if (pix_en) begin
            rgb      <= on_d ? (valid_d ? pixel_in : BG_COLOR) : 12'h000;
            hsync    <= hs_d;
            vsync    <= vs_d;
            video_on <= on_d;
        end
    end

    assign vga_r = rgb_r(rgb);
    assign vga_g = rgb_g(rgb);
    assign vga_b = rgb_b(rgb);

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- VGA timing master that sits on the opposite end of the h_cnt/v_cnt scan interface used by the text and sprite pixel generators, such as the game-over screen renderer.
- Divides the system clock into a pixel tick and runs the horizontal and vertical counters, which it broadcasts to all pixel generators.
- Samples each generator's 12-bit pixel and valid flag back, aligned to the generators' memory read latency.
- Drives the registered RGB444, hsync and vsync pins, plus a frame_start strobe for game logic.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (100 MHz to 25 MHz); legal range 1..16.
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- PIPE_LAT, 1, pixel ticks from counter presentation to pixel_in being valid; legal range 1..4.
- BG_COLOR, 12'h000, colour shown in the active area when no generator asserts valid.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- h_cnt, output, 10, current horizontal position 0..H_TOTAL-1, broadcast to pixel generators.
- v_cnt, output, 10, current vertical position 0..V_TOTAL-1.
- pix_en, output, 1, one-clk pixel tick strobe.
- pixel_in, input, 12, generator colour {R,G,B}; valid PIPE_LAT ticks after the counts it corresponds to.
- pixel_valid, input, 1, generator coverage flag; combinational from h_cnt/v_cnt, same-tick.
- vga_r, output, 4, red.
- vga_g, output, 4, green.
- vga_b, output, 4, blue.
- hsync, output, 1, active-low horizontal sync.
- vsync, output, 1, active-low vertical sync.
- video_on, output, 1, active area flag, aligned with the RGB outputs.
- frame_start, output, 1, one-clk pulse when the scan wraps to (0,0).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). With CLK_DIV=1, pix_en is constantly 1 outside reset.
- Counters advance only on pix_en.
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments when h_cnt wraps; at V_TOTAL-1 it wraps to 0.
  - Arithmetic is unsigned 10-bit and never exceeds the totals.
- Raw timing decode, combinational from the counters:
  - hs_raw = 0 for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 656..751; 1 otherwise.
  - vs_raw = 0 for v_cnt in 490..491; 1 otherwise.
  - on_raw = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- Alignment pipeline: hs_raw, vs_raw, on_raw and pixel_valid enter a PIPE_LAT-deep shift register that advances only on pix_en.
- Output register, updated on pix_en:
  - If on_d: rgb = pixel_valid_d ? pixel_in : BG_COLOR.
  - Otherwise: rgb = 12'h000, forced black during blanking.
  - hsync = hs_d, vsync = vs_d, video_on = on_d.
  - Total latency from counts to pins is PIPE_LAT+1 pixel ticks, identical for RGB and syncs.
- pixel_in handling:
  - Sampled only on pix_en.
  - Between ticks it may glitch; that has no effect on the outputs.
- frame_start: high for exactly the one clk in which pix_en=1 and the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is never asserted as a result of reset.
- Reset values, applied one clk after rst is sampled high:
  - div_cnt=0, h_cnt=0, v_cnt=0, pix_en=0.
  - All pipeline stages cleared to on=0, valid=0, hs=1, vs=1.
  - rgb=0, hsync=1, vsync=1, video_on=0, frame_start=0.
- Reset mid-frame: same values regardless of current position.
  - The first pix_en after release occurs on the CLK_DIV-th clk after rst deasserts.
  - h_cnt then goes 0→1, with no pulse for the (0,0) position.
- rst held high: all outputs hold their reset values and pix_en stays 0.

Decomposition:
- Package vga_pkg holds:
  - typedef rgb12_t (12-bit {r,g,b}) and the field slice helpers;
  - the default 640x480@60 timing constants and H_TOTAL/V_TOTAL localparams, so the pixel generators share the same bounds.
- Sub-module vga_delay_line: parameterised WIDTH/DEPTH shift register with enable and synchronous reset value, instantiated once for the {hs, vs, on, valid} bundle.

Test Plan:
- Reset, then free run with CLK_DIV=4 -> pix_en every 4th clk; h_cnt 799→0 with v_cnt+1; after 800*525 ticks (1,680,000 clks), back to (0,0) with one frame_start pulse.
- Sync widths -> hsync low for exactly 96 ticks, starting PIPE_LAT+1 ticks after h_cnt=656; vsync low for exactly 2 lines, starting at line 490 (delayed).
- Active pixel: at (100,50) drive pixel_valid=1, then pixel_in=12'hF0A after PIPE_LAT ticks -> vga_r=F, vga_g=0, vga_b=A at PIPE_LAT+1 ticks. Same point with pixel_valid=0 -> BG_COLOR.
- Blanking: at h_cnt=700, drive pixel_valid=1 and pixel_in=12'hFFF -> rgb=0, video_on=0.
- Mid-line reset: assert rst at h_cnt=300, v_cnt=200 -> next clk h_cnt=0, v_cnt=0, hsync=1, vsync=1, rgb=0. After release, first pix_en 4 clks later; no frame_start.
- CLK_DIV=1 build -> pix_en constantly 1; pipeline alignment and frame_start period (420,000 clks) hold.
